imem_responder: RTL and testbench
=================================

# imem_responder

Responder side of the fetch-to-instruction-memory interface. It accepts one word-read request at a time from the fetch stage, returns the 16-bit instruction after a fixed, parameterized latency, and asserts `stall` so fetch holds its PC while the responder is busy. A separate write port loads program words. This block replaces the ideal single-cycle instruction memory with a multi-cycle, handshaked memory model.

## Interface
- `DEPTH_LOG2`, default 10: memory holds 2^DEPTH_LOG2 16-bit words.
- `LATENCY`, default 2: cycles from request acceptance to response; legal range 1..4.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (0 = reset).
- `req_valid`  in  1  fetch presents a read request.
- `req_addr`  in  16  byte address of the instruction (PC).
- `req_ready`  out  1  responder can accept a request this cycle.
- `resp_valid`  out  1  one-cycle pulse; `resp_data`/`resp_err` valid.
- `resp_data`  out  16  instruction word.
- `resp_err`  out  1  request address was misaligned.
- `stall`  out  1  `req_valid & ~req_ready`; fetch holds its PC.
- `wr_en`  in  1  program-load write enable.
- `wr_addr`  in  16  byte address of the write.
- `wr_data`  in  16  word to write.

## Operation
- Word index = `addr[DEPTH_LOG2:1]`. Upper bits are ignored, so addresses wrap modulo the memory size.
- A request is accepted on a rising edge when `req_valid & req_ready & rst`.
- Read data is captured on the acceptance edge.
  - A write to the same word on the same edge returns the OLD data (read-before-write).
  - A write on a later edge does not affect the in-flight response.
- Misaligned request (`req_addr[0]=1`): no memory read is performed. The response arrives with the normal latency, with `resp_err=1` and `resp_data=16'h0000`.
- FSM states and transitions:
  - IDLE: `req_ready=1`. On accept, go to RESP if `LATENCY=1`; otherwise go to BUSY with the counter loaded to `LATENCY-2`.
  - BUSY: `req_ready=0`. If the counter is 0, go to RESP; otherwise decrement the counter.
  - RESP: `resp_valid=1` and `req_ready=1`. On accept, go to RESP or BUSY exactly as from IDLE; otherwise go to IDLE.
- There is no response backpressure: fetch must consume `resp_valid` in the cycle it is asserted.
- `resp_data`/`resp_err` hold their last values after the `resp_valid` pulse. They are only meaningful while `resp_valid=1`.
- Writes:
  - `wr_en` writes `mem[wr_addr[DEPTH_LOG2:1]] <= wr_data` on any edge where `rst=1`, in any FSM state.
  - Writes are ignored while `rst=0`.
  - `wr_addr[0]` is ignored.
- Memory contents are not cleared by reset.

## Timing
- Reset:
  - While `rst=0`: `req_ready=0`, `stall=0`, and no request is accepted.
  - After the first edge with `rst=0`: state IDLE, `resp_valid=0`, `resp_data=16'h0000`, `resp_err=0`.
- Latency: for a request accepted on edge E0, `resp_valid` is high in the cycle following edge E0+(LATENCY-1).
- Throughput:
  - `LATENCY=1`: one response per cycle with back-to-back requests.
  - Otherwise: one response per LATENCY cycles, since a new request is accepted in the RESP cycle.
- `stall` is combinational from `req_valid` and the current state. It is high for LATENCY-1 cycles per back-to-back request when `LATENCY>1`.
- Reset asserted mid-operation: the in-flight request is dropped. No `resp_valid` appears for it, and the FSM returns to IDLE on that edge.
- `req_addr` may change freely while `req_ready=0`; only the value at acceptance is used.

## Test plan
- Write `16'hABCD` at address `0x0010`, then with `LATENCY=2` request `0x0010`:
  - `stall=1` for 1 cycle.
  - `resp_valid` is high 2 cycles after acceptance with `resp_data=16'hABCD`, `resp_err=0`.
- Back-to-back requests to `0x0000`, `0x0002`, `0x0004` (holding `req_valid`) with `LATENCY=1`:
  - Three consecutive `resp_valid` cycles carry the three written words in order.
  - `stall` stays 0.
- Misaligned request `0x0011`:
  - `resp_valid` arrives after LATENCY cycles with `resp_err=1`, `resp_data=16'h0000`.
  - The following aligned request returns `resp_err=0`.
- Write `16'h1111` then `16'h2222` to `0x0020`, with the second write on the same edge as acceptance of a read of `0x0020`:
  - The response is `16'h1111`.
  - A second read returns `16'h2222`.
- Address wrap with `DEPTH_LOG2=10`: write `16'h5A5A` at `0x0006`; a read of `0x0806` returns `16'h5A5A`.
- Pull `rst=0` for one cycle while BUSY (`LATENCY=3`):
  - No `resp_valid` appears.
  - `req_ready` returns to 1 the cycle after `rst=1`.
  - Memory still holds previously written data.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: handshaked, fixed-latency instruction memory for the fetch stage.
// One word read in flight at a time; a separate write port loads program words.
module imem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic [15:0] req_addr_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [15:0] resp_data_o,
    output logic        resp_err_o,
    output logic        stall_o,
    input  logic        wr_en_i,
    input  logic [15:0] wr_addr_i,
    input  logic [15:0] wr_data_i
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;

    // Counter preload for the BUSY phase; unused when a response follows acceptance directly.
    localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;

    // Word captured at acceptance, held until the response is presented.
    logic [15:0] pend_data_q, pend_data_d;
    logic        pend_err_q, pend_err_d;

    // Response registers; they only change when the FSM enters RESP.
    logic [15:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic [15:0] mem_q [WORDS];

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [15:0]           rd_word;
    logic                  rd_err;
    logic                  accept;
    logic                  unused_addr_bits;

    // Upper address bits wrap; bit 0 of a write address carries no meaning.
    assign rd_idx = req_addr_i[DEPTH_LOG2:1];
    assign wr_idx = wr_addr_i[DEPTH_LOG2:1];
    assign unused_addr_bits = ^{req_addr_i[15:DEPTH_LOG2+1], wr_addr_i[15:DEPTH_LOG2+1], wr_addr_i[0]};

    // A misaligned fetch never touches the array and returns zero with the error flag.
    assign rd_err  = req_addr_i[0];
    assign rd_word = rd_err ? 16'h0000 : mem_q[rd_idx];

    assign accept = req_valid_i & req_ready_o;

    // Program-load write port; the read above sees the pre-write value on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en_i) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    // FSM state, latency counter and data registers; synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            pend_data_q <= 16'h0000;
            pend_err_q  <= 1'b0;
            resp_data_q <= 16'h0000;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_data_q <= pend_data_d;
            pend_err_q  <= pend_err_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Next-state logic: acceptance from IDLE or RESP, countdown in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Datapath: capture on acceptance, publish to the response registers on entry to RESP.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_err_d  = pend_err_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        if (accept) begin
            pend_data_d = rd_word;
            pend_err_d  = rd_err;
        end
        if (accept && (LATENCY == 1)) begin
            resp_data_d = rd_word;
            resp_err_d  = rd_err;
        end else if ((state_q == S_BUSY) && (cnt_q == 2'd0)) begin
            resp_data_d = pend_data_q;
            resp_err_d  = pend_err_q;
        end
    end

    // Outputs: ready outside BUSY and out of reset; stall is the unmet request.
    always_comb begin
        req_ready_o  = rst_ni & (state_q != S_BUSY);
        resp_valid_o = (state_q == S_RESP);
        stall_o      = rst_ni & req_valid_i & ~req_ready_o;
    end

    assign resp_data_o = resp_data_q;
    assign resp_err_o  = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: three responders (LATENCY 1, 2, 3) driven by shared stimulus and
// checked every cycle against a transaction-level model of the fetch memory.
module tb_imem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    logic [N-1:0] rdy, rvld, rerr, stl;
    logic [15:0]  rdata [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        imem_responder #(.DEPTH_LOG2(10), .LATENCY(g + 1)) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .req_valid_i  (req_valid),
            .req_addr_i   (req_addr),
            .req_ready_o  (rdy[g]),
            .resp_valid_o (rvld[g]),
            .resp_data_o  (rdata[g]),
            .resp_err_o   (rerr[g]),
            .stall_o      (stl[g]),
            .wr_en_i      (wr_en),
            .wr_addr_i    (wr_addr),
            .wr_data_i    (wr_data)
        );
    end

    // Reference model: memory image, plus per-responder outstanding transaction.
    logic [15:0] mem_m [1024];
    int          nf     [N];   // first cycle in which a new request can be accepted
    bit          pend_v [N];
    int          pend_due [N];
    logic [15:0] pend_d [N];
    logic        pend_e [N];
    logic [15:0] last_d [N];
    logic        last_e [N];
    int          cyc   = 0;
    bit          armed = 1'b0;
    int          nresp = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        else n_pass++;
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the model past the edge.
    task automatic step(input logic rs, input logic rv, input logic [15:0] ra,
                        input logic we, input logic [15:0] wa, input logic [15:0] wd);
        @(negedge clk);
        rst_n = rs; req_valid = rv; req_addr = ra;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
        if (armed) begin
            for (int k = 0; k < N; k++) begin
                bit exp_rdy, exp_v;
                exp_rdy = rs && (cyc >= nf[k]);
                exp_v   = pend_v[k] && (pend_due[k] == cyc);
                chk($sformatf("L%0d ready", k + 1), 32'(rdy[k]), 32'(exp_rdy));
                chk($sformatf("L%0d stall", k + 1), 32'(stl[k]), 32'(rs && rv && !exp_rdy));
                chk($sformatf("L%0d rvalid", k + 1), 32'(rvld[k]), 32'(exp_v));
                if (exp_v) begin
                    last_d[k] = pend_d[k];
                    last_e[k] = pend_e[k];
                    pend_v[k] = 1'b0;
                end
                chk($sformatf("L%0d rdata", k + 1), 32'(rdata[k]), 32'(last_d[k]));
                chk($sformatf("L%0d rerr", k + 1), 32'(rerr[k]), 32'(last_e[k]));
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!rs) begin
                pend_v[k] = 1'b0;
                nf[k]     = cyc + 1;
                last_d[k] = 16'h0000;
                last_e[k] = 1'b0;
            end else if (rv && (cyc >= nf[k])) begin
                pend_v[k]   = 1'b1;
                pend_due[k] = cyc + k + 1;
                pend_e[k]   = ra[0];
                pend_d[k]   = ra[0] ? 16'h0000 : mem_m[ra[10:1]];
                nf[k]       = cyc + k + 1;
                nresp++;
            end
        end
        if (rs && we) mem_m[wa[10:1]] = wd;
        if (!rs) armed = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b1, 1'b1, a, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        step(1'b1, 1'b0, 16'h0, 1'b1, a, d);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            nf[k] = 0; pend_v[k] = 1'b0; pend_due[k] = 0;
            pend_d[k] = 16'h0; pend_e[k] = 1'b0; last_d[k] = 16'h0; last_e[k] = 1'b0;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 16'h0;
        wr_en = 1'b0; wr_addr = 16'h0; wr_data = 16'h0;

        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);

        // Preload every word so all reads are defined.
        for (int i = 0; i < 1024; i++) wr(16'(i * 2), 16'($urandom));

        // Basic read after write.
        wr(16'h0010, 16'hABCD);
        rd(16'h0010);
        idle(5);

        // Back-to-back reads with req_valid held.
        wr(16'h0000, 16'h1000); wr(16'h0002, 16'h2000); wr(16'h0004, 16'h3000);
        rd(16'h0000); rd(16'h0002); rd(16'h0004);
        idle(5);

        // Misaligned request followed by an aligned one.
        rd(16'h0011);
        idle(4);
        rd(16'h0010);
        idle(5);

        // Read-before-write on the acceptance edge, then a re-read.
        wr(16'h0020, 16'h1111);
        step(1'b1, 1'b1, 16'h0020, 1'b1, 16'h0020, 16'h2222);
        idle(5);
        rd(16'h0020);
        idle(5);

        // Address wrap.
        wr(16'h0006, 16'h5A5A);
        rd(16'h0806);
        idle(5);

        // Reset while busy; a write during reset must be ignored.
        rd(16'h0010);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0010, 16'hDEAD);
        idle(3);
        rd(16'h0010);
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic rs, rv, we;
            logic [15:0] ra, wa;
            rs = ($urandom_range(0, 59) != 0);
            rv = ($urandom_range(0, 3) != 0);
            ra = 16'($urandom);
            if ($urandom_range(0, 7) != 0) ra[0] = 1'b0;
            we = ($urandom_range(0, 2) == 0);
            wa = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            step(rs, rv, ra, we, wa, 16'($urandom));
        end

        idle(6);
        for (int k = 0; k < N; k++) chk($sformatf("L%0d drained", k + 1), 32'(pend_v[k]), 32'd0);
        chk("responses", 32'(nresp > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
